// File: rtl/round_robin_arbiter_variable_time_slice.sv
// Four-requester round-robin arbiter with a per-requester time slice.
// The current winner keeps the shared resource while it keeps requesting,
// for at most its own slice length. After that, priority rotates to the
// next requester. The grant is registered and one-hot (or all-zero).
// Handover on release or expiry happens at a single edge, so there is no
// idle bubble between two owners.
module round_robin_arbiter_variable_time_slice #(
    parameter int SLICE_W = 4,
    parameter int SLICE_0 = 1,
    parameter int SLICE_1 = 2,
    parameter int SLICE_2 = 3,
    parameter int SLICE_3 = 4
) (
    input  logic       clk,
    input  logic       rst_n,   // active-high synchronous reset despite the name
    input  logic [3:0] REQ,
    output logic [3:0] GNT
);

    // Registered arbiter state: current grant, next search start, slice budget.
    logic [3:0]         gnt_q;
    logic [1:0]         ptr_q;
    logic [SLICE_W-1:0] cnt_q;

    logic [3:0]         gnt_d;
    logic [1:0]         ptr_d;
    logic [SLICE_W-1:0] cnt_d;

    // Combinational decision helpers.
    logic [1:0]         cur_idx;
    logic               do_search;
    logic [1:0]         search_start;
    logic [2:0]         search_hit;   // {found, index}

    // Counter reload value for a requester. cnt holds "cycles left minus one",
    // so a slice of N cycles loads N-1. A slice of 2^SLICE_W loads all ones.
    function automatic logic [SLICE_W-1:0] slice_load(input logic [1:0] idx);
        logic [SLICE_W-1:0] val;
        case (idx)
            2'd0:    val = SLICE_W'(SLICE_0 - 1);
            2'd1:    val = SLICE_W'(SLICE_1 - 1);
            2'd2:    val = SLICE_W'(SLICE_2 - 1);
            default: val = SLICE_W'(SLICE_3 - 1);
        endcase
        return val;
    endfunction

    // Circular priority search. It scans start, start+1, ... modulo 4 and
    // returns the first requesting index. The loop runs from the farthest
    // candidate to the nearest, so the nearest requester is written last
    // and therefore wins.
    function automatic logic [2:0] search(input logic [3:0] req,
                                          input logic [1:0] start);
        logic [2:0] hit;
        logic [1:0] idx;
        hit = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                hit = {1'b1, idx};
            end
        end
        return hit;
    endfunction

    // One-hot to index. The grant is guaranteed one-hot whenever this result is used.
    function automatic logic [1:0] encode(input logic [3:0] onehot);
        logic [1:0] idx;
        case (onehot)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Index to one-hot grant vector.
    function automatic logic [3:0] decode(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // State register: reset clears everything and overrides any decision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            gnt_q <= 4'b0000;
            ptr_q <= 2'd0;
            cnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state decision: idle search, slice hold, or expiry/release handover.
    always_comb begin
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        cur_idx      = encode(gnt_q);
        do_search    = 1'b0;
        search_start = ptr_q;
        search_hit   = 3'b000;

        if (gnt_q == 4'b0000) begin
            // Idle: look for a requester starting at the rotating pointer.
            do_search    = 1'b1;
            search_start = ptr_q;
        end else if (REQ[cur_idx] && (cnt_q != '0)) begin
            // The owner still has budget and still requests. Other requests
            // arriving now do not preempt it.
            cnt_d = cnt_q - SLICE_W'(1);
        end else begin
            // Expiry or release. Both search past the current owner. On
            // expiry the owner may still be re-found as the last candidate.
            // On release its request bit is already low, so it cannot be
            // re-granted.
            do_search    = 1'b1;
            search_start = cur_idx + 2'd1;
        end

        if (do_search) begin
            search_hit = search(REQ, search_start);
            if (search_hit[2]) begin
                gnt_d = decode(search_hit[1:0]);
                cnt_d = slice_load(search_hit[1:0]);
                ptr_d = search_hit[1:0] + 2'd1;
            end else if (gnt_q != 4'b0000) begin
                // The owner released and nobody else requests. Go idle and
                // move the pointer past the releasing owner.
                gnt_d = 4'b0000;
                ptr_d = cur_idx + 2'd1;
            end
        end
    end

    // Output: the grant comes straight from a register, with no combinational path from REQ.
    always_comb begin
        GNT = gnt_q;
    end

endmodule

// File: tb/tb_round_robin_arbiter_variable_time_slice.sv
// Bench for the four-requester round-robin arbiter with time slices.
// A behavioural model tracks the owner, the cycles it has used, and the
// rotation pointer. The model is checked against the DUT on every cycle.
// The directed sequences also pin exact grant values.
module tb_round_robin_arbiter_variable_time_slice;

    logic       clk;
    logic       rst_n;
    logic [3:0] REQ;
    logic [3:0] GNT;

    int n_cmp;
    int n_bad;

    int slice_len[4] = '{1, 2, 3, 4};

    // Behavioural model state
    int         owner;     // -1 when idle
    int         used;      // cycles the owner has held the grant so far
    int         mptr;
    logic [3:0] exp_gnt;

    round_robin_arbiter_variable_time_slice #(
        .SLICE_W(4), .SLICE_0(1), .SLICE_1(2), .SLICE_2(3), .SLICE_3(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .REQ  (REQ),
        .GNT  (GNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: decide the owner for the coming cycle from the arbitration rules.
    always @(posedge clk) begin
        int start;
        int pick;
        bit need;
        if (rst_n) begin
            owner = -1;
            used  = 0;
            mptr  = 0;
        end else begin
            need  = 1'b0;
            start = 0;
            if (owner < 0) begin
                need  = 1'b1;
                start = mptr;
            end else if (!REQ[owner] || used >= slice_len[owner]) begin
                need  = 1'b1;
                start = owner + 1;
            end else begin
                used++;
            end
            if (need) begin
                pick = -1;
                for (int k = 0; k < 4; k++) begin
                    if (pick < 0 && REQ[(start + k) % 4]) pick = (start + k) % 4;
                end
                if (pick >= 0) begin
                    owner = pick;
                    used  = 1;
                    mptr  = (pick + 1) % 4;
                end else begin
                    if (owner >= 0) mptr = (owner + 1) % 4;
                    owner = -1;
                    used  = 0;
                end
            end
        end
        exp_gnt = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
    end

    // Compare process: check the DUT against the model one step after every edge.
    always @(posedge clk) begin
        #1;
        n_cmp++;
        if (GNT !== exp_gnt) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t GNT=%b expected=%b", $time, GNT, exp_gnt);
        end
    end

    task automatic cyc(input logic [3:0] r, input logic rs);
        @(negedge clk);
        REQ   = r;
        rst_n = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] want);
        n_cmp++;
        if (GNT !== want) begin
            n_bad++;
            $display("FAIL %s GNT=%b expected=%b", name, GNT, want);
        end
    endtask

    logic [3:0] rot_exp [11] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                 4'b0001};

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        owner   = -1;
        used    = 0;
        mptr    = 0;
        exp_gnt = 4'b0000;
        REQ     = 4'b0000;
        rst_n   = 1'b1;

        // Reset then idle
        cyc(4'b1111, 1'b1);  chk("reset_gnt", 4'b0000);
        cyc(4'b0000, 1'b0);  chk("idle_0", 4'b0000);
        cyc(4'b0000, 1'b0);  chk("idle_1", 4'b0000);

        // Single holder, re-granted continuously
        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(4'b1000, 1'b0);  chk($sformatf("single_%0d", i), 4'b1000);
        end

        // Full rotation
        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 11; i++) begin
            cyc(4'b1111, 1'b0);  chk($sformatf("rotation_%0d", i), rot_exp[i]);
        end

        // Release and pointer
        cyc(4'b0000, 1'b1);
        cyc(4'b0100, 1'b0);  chk("rel_grant", 4'b0100);
        cyc(4'b0000, 1'b0);  chk("rel_idle", 4'b0000);
        cyc(4'b0101, 1'b0);  chk("rel_ptr3", 4'b0001);

        // Zero-bubble handover, then reset mid-grant
        cyc(4'b0000, 1'b1);
        cyc(4'b0110, 1'b0);  chk("hand_first", 4'b0010);
        cyc(4'b0100, 1'b0);  chk("hand_next", 4'b0100);
        cyc(4'b0100, 1'b0);  chk("hold_2", 4'b0100);
        cyc(4'b0100, 1'b1);  chk("mid_reset", 4'b0000);
        cyc(4'b0110, 1'b0);  chk("post_reset", 4'b0010);

        // A new request does not preempt before expiry
        cyc(4'b0000, 1'b1);
        cyc(4'b1000, 1'b0);  chk("nopre_0", 4'b1000);
        cyc(4'b1001, 1'b0);  chk("nopre_1", 4'b1000);
        cyc(4'b1001, 1'b0);  chk("nopre_2", 4'b1000);
        cyc(4'b1001, 1'b0);  chk("nopre_3", 4'b1000);
        cyc(4'b1001, 1'b0);  chk("nopre_exp", 4'b0001);

        // Expiry coinciding with release counts as a release and moves ptr to 1
        cyc(4'b0000, 1'b1);
        cyc(4'b0001, 1'b0);  chk("exprel_g", 4'b0001);
        cyc(4'b0000, 1'b0);  chk("exprel_idle", 4'b0000);
        cyc(4'b0011, 1'b0);  chk("exprel_ptr1", 4'b0010);

        // Pseudo-random request traffic, checked by the model only
        for (int i = 0; i < 300; i++) begin
            cyc(4'($urandom_range(0, 15)), (i % 97) == 50);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter_variable_time_slice.md
# round_robin_arbiter_variable_time_slice

Four-requester round-robin arbiter with a per-requester time slice. It grants one shared resource to at most one requester at a time. The winner keeps the grant while it keeps requesting, up to its own slice length, and then priority rotates. It sits between four bus/resource masters and a single shared target. The grant is registered and one-hot.

## Interface
- SLICE_W, 4: width of the slice counter.
- SLICE_0, 1: grant length in cycles for requester 0 (legal range 1..2^SLICE_W).
- SLICE_1, 2: grant length in cycles for requester 1.
- SLICE_2, 3: grant length in cycles for requester 2.
- SLICE_3, 4: grant length in cycles for requester 3.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-high reset (asserted = 1, sampled on rising clk edge). The name is kept per codebase convention.
- REQ  input  4  request vector; bit i = requester i wants the resource. Level-sensitive, no handshake beyond level.
- GNT  output  4  registered grant; one-hot or all-zero.

## Operation
- State registers:
  - GNT[3:0]
  - ptr[1:0]: index where the next search starts
  - cnt[SLICE_W-1:0]: cycles remaining in the current slice minus one
- Search(start): scans indices start, start+1, … modulo 4 and returns the first i with REQ[i]=1, or none.
- Idle (GNT==0):
  - If Search(ptr) finds i: GNT <= onehot(i), cnt <= SLICE_i-1.
  - Else: stay idle; ptr unchanged.
- Granted (GNT==onehot(i)):
  - REQ[i]=1 and cnt!=0: hold the grant; cnt <= cnt-1.
  - REQ[i]=1 and cnt==0 (slice expired): Search(i+1).
    - If it finds j≠i, grant j with cnt <= SLICE_j-1.
    - If only i is requesting, re-grant i with cnt reloaded. The grant stays continuous with no gap.
  - REQ[i]=0 (voluntary release): Search(i+1).
    - Found j: grant j, cnt <= SLICE_j-1.
    - None: GNT <= 0, ptr <= i+1 (mod 4).
- On every new grant to j: ptr <= j+1 (mod 4).
- GNT is never multi-hot. GNT is never asserted to a requester whose REQ was 0 at the deciding edge.
- Fairness: with all four requesting continuously, each requester gets exactly SLICE_i consecutive cycles per rotation, in order 0→1→2→3→0.

## Timing
- Reset value: GNT=4'b0000, ptr=0, cnt=0. Reset has priority over all other logic.
- Reset asserted mid-grant clears GNT at the next edge, regardless of REQ.
- Latency: REQ sampled at edge k produces GNT valid after edge k (one register stage). There is no combinational path from REQ to GNT.
- Handover on release or expiry is zero-bubble: the old grant drops and the new grant rises at the same edge.
- Release latency: dropping REQ[i] before edge k removes GNT[i] after edge k.
- Slice length counts cycles with GNT[i]=1, including the first cycle.
- Wrap-around:
  - Search index and ptr wrap 3→0.
  - cnt never underflows, because it is reloaded whenever it reaches 0 under request.
- Simultaneous events:
  - Expiry and release in the same cycle is treated as a release.
  - New requests arriving during a grant do not preempt it before expiry or release.

## Test plan
- Reset then idle: rst_n=1 for one edge with REQ=1111 → GNT=0000 after that edge. rst_n=0, REQ=0000 → GNT stays 0000.
- Single holder: from reset, REQ=1000 held 6 cycles → GNT=1000 from edge 1 onward with no gap, re-granted every 4 cycles.
- Full rotation: from reset, REQ=1111 held → GNT sequence 0001×1, 0010×2, 0100×3, 1000×4, then 0001 again.
- Release and pointer: REQ=0100 → GNT=0100. Then REQ=0000 → GNT=0000 (ptr=3). Then REQ=0101 → GNT=0001.
- Zero-bubble handover: GNT=0010 with REQ=0110; drop REQ to 0100 → GNT=0100 at the next edge, with no 0000 cycle.
- Reset mid-operation: GNT=0100 with REQ=0100, assert rst_n=1 → GNT=0000 next edge. Deassert with REQ=0110 → GNT=0010 (ptr back to 0).
